// File: rtl/pc_fetch_stage.sv
// -----------------------------------------------------------------------------
// pc_fetch_stage
//   Program counter and instruction register in front of the picoMIPS decoder.
//   The PC drives the program ROM address directly. The combinational ROM word
//   is captured into the IR. The decoder's PCincr/PCabsbranch/PCrelbranch
//   commands form the next PC. A taken branch discards the word already being
//   fetched, which leaves one bubble cycle.
//
// Ports
//   clk          in   system clock, rising-edge state updates
//   n_reset      in   asynchronous active-low reset
//   stall        in   hold every register this cycle
//   PCincr       in   decoder: advance sequentially
//   PCabsbranch  in   decoder: jump to Branchaddr (wins over PCrelbranch)
//   PCrelbranch  in   decoder: jump to ir_pc + Branchaddr
//   Branchaddr   in   absolute target or signed offset
//   prog_data    in   ROM word at prog_addr
//   prog_addr    out  fetch PC (combinational copy of the PC register)
//   instr        out  IR when valid, else {NOP_OPC, zeros}
//   opcode       out  top 6 bits of instr
//   ir_pc        out  address of the instruction held in the IR
//   instr_valid  out  IR holds a real instruction
//   branch_count out  saturating count of taken branches (PC_BRANCH_COUNT_EN)
//
// Build option
//   PC_BRANCH_COUNT_EN : adds the BCNT_WIDTH parameter and the branch_count port
// -----------------------------------------------------------------------------
// state     | meaning
// ST_EMPTY  | IR content is stale (after reset or in a branch bubble); decoder sees NOP
// ST_VALID  | IR holds the instruction at ir_pc; decoder commands are honoured
// -----------------------------------------------------------------------------
module pc_fetch_stage #(
   parameter int         PC_WIDTH    = 6,
   parameter int         INSTR_WIDTH = 20,
   parameter logic [5:0] NOP_OPC     = 6'b010000
`ifdef PC_BRANCH_COUNT_EN
   ,parameter int        BCNT_WIDTH  = 8
`endif
) (
   input  logic                   clk,
   input  logic                   n_reset,
   input  logic                   stall,
   input  logic                   PCincr,
   input  logic                   PCabsbranch,
   input  logic                   PCrelbranch,
   input  logic [PC_WIDTH-1:0]    Branchaddr,
   input  logic [INSTR_WIDTH-1:0] prog_data,
   output logic [PC_WIDTH-1:0]    prog_addr,
   output logic [INSTR_WIDTH-1:0] instr,
   output logic [5:0]             opcode,
   output logic [PC_WIDTH-1:0]    ir_pc,
   output logic                   instr_valid
`ifdef PC_BRANCH_COUNT_EN
   ,output logic [BCNT_WIDTH-1:0] branch_count
`endif
);

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_VALID = 1'b1
   } state_t;

   localparam logic [PC_WIDTH-1:0] PC_ONE = {{(PC_WIDTH-1){1'b0}}, 1'b1};

   state_t                 r_state, w_state_nxt;
   logic [PC_WIDTH-1:0]    r_pc, w_pc_nxt;
   logic [PC_WIDTH-1:0]    r_ir_pc, w_ir_pc_nxt;
   logic [INSTR_WIDTH-1:0] r_ir, w_ir_nxt;
   logic                   w_valid;
   logic                   w_take_abs;
   logic                   w_take_rel;

   assign w_valid = (r_state == ST_VALID);

   // Decoder commands only mean something while the IR holds a real instruction.
   assign w_take_abs = !stall && w_valid && PCabsbranch;
   assign w_take_rel = !stall && w_valid && !PCabsbranch && PCrelbranch;

   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      w_ir_pc_nxt = r_ir_pc;
      w_ir_nxt    = r_ir;
      if (w_take_abs) begin
         w_pc_nxt    = Branchaddr;
         w_state_nxt = ST_EMPTY;
      end else if (w_take_rel) begin
         // Offset is two's complement; the modular add gives the signed result.
         w_pc_nxt    = r_ir_pc + Branchaddr;
         w_state_nxt = ST_EMPTY;
      end else if (!stall && (!w_valid || PCincr)) begin
         w_ir_nxt    = prog_data;
         w_ir_pc_nxt = r_pc;
         w_pc_nxt    = r_pc + PC_ONE;
         w_state_nxt = ST_VALID;
      end
   end

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         r_state <= ST_EMPTY;
         r_pc    <= '0;
         r_ir_pc <= '0;
         r_ir    <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_pc    <= w_pc_nxt;
         r_ir_pc <= w_ir_pc_nxt;
         r_ir    <= w_ir_nxt;
      end
   end

   assign prog_addr   = r_pc;
   assign instr       = w_valid ? r_ir : {NOP_OPC, {(INSTR_WIDTH-6){1'b0}}};
   assign opcode      = instr[INSTR_WIDTH-1 -: 6];
   assign ir_pc       = r_ir_pc;
   assign instr_valid = w_valid;

`ifdef PC_BRANCH_COUNT_EN
   logic [BCNT_WIDTH-1:0] r_bcnt;
   logic                  w_taken;

   assign w_taken = w_take_abs || w_take_rel;

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         r_bcnt <= '0;
      end else if (w_taken && (r_bcnt != {BCNT_WIDTH{1'b1}})) begin
         r_bcnt <= r_bcnt + {{(BCNT_WIDTH-1){1'b0}}, 1'b1};
      end
   end

   assign branch_count = r_bcnt;
`endif

endmodule
